accum_cmd_seq: RTL and testbench
================================

Name: accum_cmd_seq

Overview:
Command sequencer placed directly upstream of the 4-stage pipelined accumulator. It accepts one command at a time on a valid/ready handshake: operation, operand, repeat count and an optional clear-first flag. It drives the accumulator's clr/add_sub/D inputs for the requested number of cycles and waits out the pipeline latency. It then captures the accumulator output Q and presents it with a one-cycle result_valid pulse.

Parameters:
WIDTH, 16, operand/result width; must equal the accumulator's WIDTH.
CNT_W, 8, width of the repeat-count field.
PIPE_LAT, 4, accumulator latency in cycles, from sampled input to reflected Q.

Ports:
clock  in  1  system clock, rising edge
rstn  in  1  asynchronous reset, active low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  1  0 add, 1 sub
cmd_clr  in  1  first issue cycle also asserts acc_clr
cmd_data  in  WIDTH  operand applied every issue cycle
cmd_count  in  CNT_W  number of issue cycles; 0 treated as 1
acc_clr  out  1  to accumulator clr
acc_add_sub  out  1  to accumulator add_sub
acc_d  out  WIDTH  to accumulator D
acc_q  in  WIDTH  from accumulator Q
result  out  WIDTH  captured accumulator value
result_valid  out  1  one-cycle pulse; result is valid

Behaviour:
- Clock and reset: one clock (clock). Reset rstn is asynchronous and active-low.
- Reset values: cmd_ready=0 while rstn=0, then 1 from the first cycle after release. acc_clr=0, acc_add_sub=0, acc_d=0, result=0, result_valid=0. State is IDLE.
- Accumulator outputs are registered. The idle drive is clr=0, add_sub=0, D=0 ("add zero"), which holds the accumulator value.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: cmd_ready=1.
  - Accept occurs at the edge where cmd_valid and cmd_ready are both 1.
  - On accept, latch op, data and n=max(cmd_count,1).
  - At the same edge, load acc_d=cmd_data, acc_add_sub=cmd_op, acc_clr=cmd_clr. Go to ISSUE.
- ISSUE: cmd_ready=0. The remaining-count register starts at n and decrements each cycle.
  - acc_clr is high only in the first ISSUE cycle.
  - acc_d and acc_add_sub are held for exactly n cycles.
  - At the edge that ends the last issue cycle: acc_* return to the idle drive, the drain counter loads PIPE_LAT, go to DRAIN.
- DRAIN: counts down. At the edge where the counter reaches 1, result<=acc_q, go to DONE.
- DONE: result_valid=1 for exactly one cycle, then IDLE. result holds its value until the next capture.
- Timing: accept at end of cycle a → issue cycles a+1..a+n → capture at end of cycle a+n+PIPE_LAT → result_valid in cycle a+n+PIPE_LAT+1. The next accept is possible at the end of the cycle after DONE.
- Handshake:
  - cmd_valid while not ready is ignored; the command must be held by the producer.
  - cmd_* values are sampled only at accept.
- Arithmetic is modulo 2^WIDTH (the accumulator wraps). The sequencer does no arithmetic on data.
- Reset mid-operation: all state returns to reset values immediately. The accumulator shares rstn, so no stale pipeline contents remain. Any in-flight command is dropped with no result_valid.
- cmd_count at maximum (2^CNT_W-1) must issue exactly that many cycles, with no wrap of the remaining counter.

Optional Feature:
Macro ACC_SEQ_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 sampled in ISSUE stops issuing at that edge: acc_* go to the idle drive and the block goes to DRAIN with a full PIPE_LAT.
  - The partial result is captured and result_valid pulses as normal.
  - Adds output result_aborted, valid with result_valid; it is 0 for normally completed commands.
  - abort in IDLE, DRAIN or DONE is ignored.
- Undefined: no abort port and no result_aborted port. Behaviour is as above.

Decomposition:
- Shared package acc_pkg:
  - localparam ACC_PIPE_LAT=4.
  - Op encodings ACC_OP_ADD=1'b0, ACC_OP_SUB=1'b1.
  - Sequencer state encoding (IDLE/ISSUE/DRAIN/DONE).
- One natural sub-module, acc_seq_cnt: a loadable down-counter with a terminal-count flag. It is instantiated twice: issue count (CNT_W) and drain count (clog2(PIPE_LAT)+1).

Test Plan:
The bench uses a behavioural accumulator model with 4-cycle latency, WIDTH=16.
- Clear then add: clr=1, add, data=0x0003, count=5, accepted end of cycle 10 → acc_clr high in cycle 11 only; result_valid in cycle 20; result=0x000F.
- Chained sub, no clear: after the previous command, sub data=0x0002 count=3 → result=0x0009.
- Wrap: clr sub data=0x0001 count=1 → result=0xFFFF. clr add data=0x8000 count=2 → result=0x0000.
- Count edge cases:
  - count=0 behaves as count=1 (one issue cycle).
  - count=255 → exactly 255 issue cycles; result=(255*data) mod 2^16.
- Back-pressure: cmd_valid held high with a second command during a busy period → cmd_ready=0 until IDLE; the second command is accepted one cycle after its result_valid; both results are correct.
- Reset mid-ISSUE (cycle 3 of count=5): rstn low → acc_*=0, result_valid never pulses. After release, cmd_ready=1 and a fresh clr add 0x0004 count=1 → result=0x0004.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator and its command sequencer.
package acc_pkg;

  localparam int ACC_PIPE_LAT = 4;

  localparam logic ACC_OP_ADD = 1'b0;
  localparam logic ACC_OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/acc_seq_cnt.sv
// Loadable down-counter; tc flags the final count value of 1.
module acc_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         rstn,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  // Saturates at zero so a maximum load never wraps.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/accum_cmd_seq.sv
// Command sequencer driving the pipelined accumulator's clr/add_sub/D inputs.
// Optional abort input and result_aborted output under `ACC_SEQ_ABORT_EN.
module accum_cmd_seq
  import acc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CNT_W    = 8,
  parameter int PIPE_LAT = ACC_PIPE_LAT
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic             cmd_clr,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
`ifdef ACC_SEQ_ABORT_EN
  input  logic             abort,
  output logic             result_aborted,
`endif
  output logic             acc_clr,
  output logic             acc_add_sub,
  output logic [WIDTH-1:0] acc_d,
  input  logic [WIDTH-1:0] acc_q,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  localparam int DW = $clog2(PIPE_LAT) + 1;

  seq_state_e       state, state_nxt;
  logic             accept;
  logic             abort_now;
  logic             issue_end;
  logic             drain_end;
  logic             iss_tc;
  logic             drn_tc;
  logic [CNT_W-1:0] issue_n;

  assign accept    = cmd_valid && cmd_ready;
  assign issue_n   = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
  assign issue_end = (state == ST_ISSUE) && (iss_tc || abort_now);
  assign drain_end = (state == ST_DRAIN) && drn_tc;

`ifdef ACC_SEQ_ABORT_EN
  assign abort_now = abort;
`else
  assign abort_now = 1'b0;
`endif

  acc_seq_cnt #(.W(CNT_W)) u_issue_cnt (
    .clock    (clock),
    .rstn     (rstn),
    .load     (accept),
    .dec      (state == ST_ISSUE),
    .load_val (issue_n),
    .tc       (iss_tc)
  );

  acc_seq_cnt #(.W(DW)) u_drain_cnt (
    .clock    (clock),
    .rstn     (rstn),
    .load     (issue_end),
    .dec      (state == ST_DRAIN),
    .load_val (DW'(PIPE_LAT)),
    .tc       (drn_tc)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept)    state_nxt = ST_ISSUE;
      ST_ISSUE: if (issue_end) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drn_tc)    state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Accumulator drive is loaded at accept and held; clr lasts one cycle.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      cmd_ready    <= 1'b0;
      acc_clr      <= 1'b0;
      acc_add_sub  <= ACC_OP_ADD;
      acc_d        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      cmd_ready    <= (state_nxt == ST_IDLE);
      result_valid <= drain_end;
      if (accept) begin
        acc_clr     <= cmd_clr;
        acc_add_sub <= cmd_op;
        acc_d       <= cmd_data;
      end else if (issue_end) begin
        acc_clr     <= 1'b0;
        acc_add_sub <= ACC_OP_ADD;
        acc_d       <= '0;
      end else begin
        acc_clr     <= 1'b0;
      end
      if (drain_end) begin
        result <= acc_q;
      end
    end
  end

`ifdef ACC_SEQ_ABORT_EN
  logic aborted_r;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      aborted_r      <= 1'b0;
      result_aborted <= 1'b0;
    end else begin
      if (accept) begin
        aborted_r <= 1'b0;
      end else if (issue_end) begin
        aborted_r <= abort;
      end
      result_aborted <= drain_end && aborted_r;
    end
  end
`endif

endmodule

// File: tb/tb_accum_cmd_seq.sv
// Bench for accum_cmd_seq: behavioural accumulator plus command-level reference model.
module tb_accum_cmd_seq;
  import acc_pkg::*;

  localparam int WIDTH    = 16;
  localparam int CNT_W    = 8;
  localparam int PIPE_LAT = 4;
  localparam int MAXC     = 8192;

  logic             clock = 1'b0;
  logic             rstn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_op = 1'b0;
  logic             cmd_clr = 1'b0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             cmd_ready;
  logic             acc_clr;
  logic             acc_add_sub;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result;
  logic             result_valid;
`ifdef ACC_SEQ_ABORT_EN
  logic             abort = 1'b0;
  logic             result_aborted;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  accum_cmd_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clock        (clock),
    .rstn         (rstn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_clr      (cmd_clr),
    .cmd_data     (cmd_data),
    .cmd_count    (cmd_count),
`ifdef ACC_SEQ_ABORT_EN
    .abort        (abort),
    .result_aborted(result_aborted),
`endif
    .acc_clr      (acc_clr),
    .acc_add_sub  (acc_add_sub),
    .acc_d        (acc_d),
    .acc_q        (acc_q),
    .result       (result),
    .result_valid (result_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // Behavioural 4-cycle accumulator sharing rstn with the DUT.
  logic [WIDTH-1:0] acc_pipe [0:3];
  assign acc_q = acc_pipe[3];

  always @(posedge clock or negedge rstn) begin : acc_env
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] nv;
    if (!rstn) begin
      for (int i = 0; i < 4; i++) acc_pipe[i] <= '0;
    end else begin
      base = acc_clr ? '0 : acc_pipe[0];
      nv   = acc_add_sub ? base - acc_d : base + acc_d;
      acc_pipe[0] <= nv;
      acc_pipe[1] <= acc_pipe[0];
      acc_pipe[2] <= acc_pipe[1];
      acc_pipe[3] <= acc_pipe[2];
    end
  end

  // Command-level reference: per-cycle expected outputs scheduled at accept.
  bit             exp_clr [MAXC];
  bit             exp_as  [MAXC];
  bit [WIDTH-1:0] exp_d   [MAXC];
  bit             exp_rv  [MAXC];
  bit [WIDTH-1:0] exp_res [MAXC];
  int             cyc = 0;
  int             ready_at = MAXC;
  bit [WIDTH-1:0] m_total = '0;

  always @(posedge clock) begin : spec_model
    int a;
    int n;
    a = cyc;
    if (!rstn) begin
      m_total  = '0;
      ready_at = a + 2;
      for (int c = a + 1; c < MAXC && c < a + 300; c++) begin
        exp_clr[c] = 1'b0; exp_as[c] = 1'b0; exp_d[c] = '0; exp_rv[c] = 1'b0;
      end
    end else if (cmd_valid && (a >= ready_at)) begin
      n = (cmd_count == 0) ? 1 : int'(cmd_count);
      if (cmd_clr) m_total = '0;
      if (cmd_op) m_total = m_total - WIDTH'(n * int'(cmd_data));
      else        m_total = m_total + WIDTH'(n * int'(cmd_data));
      for (int k = 1; k <= n; k++) begin
        if (a + k < MAXC) begin
          exp_clr[a+k] = cmd_clr && (k == 1);
          exp_as[a+k]  = cmd_op;
          exp_d[a+k]   = cmd_data;
        end
      end
      if (a + n + PIPE_LAT + 1 < MAXC) begin
        exp_rv[a+n+PIPE_LAT+1]  = 1'b1;
        exp_res[a+n+PIPE_LAT+1] = m_total;
      end
      ready_at = a + n + PIPE_LAT + 2;
    end
    cyc = a + 1;
  end

  bit [WIDTH-1:0] cur_res = '0;
  bit [WIDTH-1:0] res_q [$];
  int             rvc_q [$];
  int             clr_q [$];

  always @(negedge clock) begin : compare
    if (cyc < MAXC) begin
      if (!rstn) begin
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_acc_clr", 32'(acc_clr), 0);
        chk("rst_acc_add_sub", 32'(acc_add_sub), 0);
        chk("rst_acc_d", 32'(acc_d), 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_result", 32'(result), 0);
        cur_res = '0;
      end else begin
        if (exp_rv[cyc]) cur_res = exp_res[cyc];
        chk("cmd_ready", 32'(cmd_ready), 32'(cyc >= ready_at));
        chk("acc_clr", 32'(acc_clr), 32'(exp_clr[cyc]));
        chk("acc_add_sub", 32'(acc_add_sub), 32'(exp_as[cyc]));
        chk("acc_d", 32'(acc_d), 32'(exp_d[cyc]));
        chk("result_valid", 32'(result_valid), 32'(exp_rv[cyc]));
        chk("result", 32'(result), 32'(cur_res));
`ifdef ACC_SEQ_ABORT_EN
        chk("result_aborted", 32'(result_aborted), 0);
`endif
        if (result_valid === 1'b1) begin
          res_q.push_back(result);
          rvc_q.push_back(cyc);
        end
        if (acc_clr === 1'b1) clr_q.push_back(cyc);
      end
    end
  end

  task automatic present(input bit clr, input bit op, input bit [WIDTH-1:0] d, input bit [CNT_W-1:0] n);
    cmd_valid = 1'b1; cmd_clr = clr; cmd_op = op; cmd_data = d; cmd_count = n;
  endtask

  // Returns the cycle whose closing edge accepted the presented command.
  task automatic wait_accept(output int ac);
    int t;
    t  = 0;
    ac = -1;
    while (1) begin
      @(negedge clock);
      if (cmd_ready === 1'b1) begin
        ac = cyc;
        break;
      end
      t++;
      if (t > 400) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clock);
    #2;
  endtask

  task automatic issue(input bit clr, input bit op, input bit [WIDTH-1:0] d, input bit [CNT_W-1:0] n, output int ac);
    present(clr, op, d, n);
    wait_accept(ac);
    cmd_valid = 1'b0;
    cmd_data  = WIDTH'($urandom);
    cmd_count = CNT_W'($urandom);
  endtask

  task automatic wait_result(output bit [WIDTH-1:0] r, output int rc);
    int t;
    t  = 0;
    r  = '0;
    rc = -1;
    while (res_q.size() == 0 && t < 400) begin
      @(posedge clock);
      t++;
    end
    if (res_q.size() == 0) begin
      chk("result_timeout", 0, 1);
    end else begin
      r  = res_q.pop_front();
      rc = rvc_q.pop_front();
    end
    #2;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int             ac, ac2, rc, rc2, gap;
    bit [WIDTH-1:0] r, r2;

    // Reset
    repeat (3) @(posedge clock);
    #2;
    rstn = 1'b1;
    @(negedge clock);
    chk("release_ready_low", 32'(cmd_ready), 0);
    @(negedge clock);
    chk("ready_after_release", 32'(cmd_ready), 1);
    @(posedge clock);
    #2;

    // Clear then add
    clr_q.delete();
    issue(1'b1, ACC_OP_ADD, 16'h0003, 8'd5, ac);
    wait_result(r, rc);
    chk("t1_result", 32'(r), 32'h000F);
    chk("t1_rv_latency", rc - ac, 10);
    chk("t1_clr_cycles", clr_q.size(), 1);
    if (clr_q.size() > 0) chk("t1_clr_offset", clr_q[0] - ac, 1);

    // Chained subtract without clear
    issue(1'b0, ACC_OP_SUB, 16'h0002, 8'd3, ac);
    wait_result(r, rc);
    chk("t2_result", 32'(r), 32'h0009);

    // Wrap-around
    issue(1'b1, ACC_OP_SUB, 16'h0001, 8'd1, ac);
    wait_result(r, rc);
    chk("t3_result", 32'(r), 32'hFFFF);
    issue(1'b1, ACC_OP_ADD, 16'h8000, 8'd2, ac);
    wait_result(r, rc);
    chk("t4_result", 32'(r), 32'h0000);

    // Count zero behaves as one
    issue(1'b1, ACC_OP_ADD, 16'h0007, 8'd0, ac);
    wait_result(r, rc);
    chk("t5_result", 32'(r), 32'h0007);
    chk("t5_rv_latency", rc - ac, 6);

    // Maximum count
    issue(1'b1, ACC_OP_ADD, 16'h0123, 8'd255, ac);
    wait_result(r, rc);
    chk("t6_result", 32'(r), 32'h21DD);
    chk("t6_rv_latency", rc - ac, 260);

    // Back-pressure: second command held valid while busy
    present(1'b1, ACC_OP_ADD, 16'h0005, 8'd4);
    wait_accept(ac);
    present(1'b0, ACC_OP_ADD, 16'h0010, 8'd2);
    wait_accept(ac2);
    cmd_valid = 1'b0;
    wait_result(r, rc);
    wait_result(r2, rc2);
    chk("t7_first", 32'(r), 32'h0014);
    chk("t7_second", 32'(r2), 32'h0034);
    chk("t7_accept_gap", ac2 - rc, 1);

    // Reset in the third issue cycle of a count-5 command
    issue(1'b1, ACC_OP_ADD, 16'h0009, 8'd5, ac);
    @(posedge clock);
    @(posedge clock);
    #2;
    rstn = 1'b0;
    @(negedge clock);
    chk("t8_rst_acc_d", 32'(acc_d), 0);
    chk("t8_rst_ready", 32'(cmd_ready), 0);
    @(posedge clock);
    #2;
    rstn = 1'b1;
    res_q.delete();
    rvc_q.delete();
    repeat (20) @(posedge clock);
    chk("t8_no_result", res_q.size(), 0);
    #2;
    issue(1'b1, ACC_OP_ADD, 16'h0004, 8'd1, ac);
    wait_result(r, rc);
    chk("t8_fresh_result", 32'(r), 32'h0004);

    // Randomized commands, some presented back-to-back while busy
    for (int i = 0; i < 40; i++) begin
      issue(($urandom_range(0, 3) == 0), 1'($urandom), WIDTH'($urandom),
            CNT_W'($urandom_range(0, 12)), ac);
      gap = $urandom_range(0, 3);
      repeat (gap * 4) @(posedge clock);
      #2;
    end
    repeat (40) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
